// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central hazard controller for the 5-stage pipeline.
// Derives stall / bubble / squash / freeze controls combinationally from the
// current ID operands, the EX load, EX redirects and memory busy. It also
// registers the last decision, runs a memory-freeze watchdog and, when
// HAZARD_PERF_CNT_EN is defined, keeps saturating hazard performance counters.
//
// State | meaning
// ------+-----------------------------------------------------------
// RUN   | 00: normal flow, PC and IF/ID advance
// STALL | 01: load-use, hold PC and IF/ID, bubble into ID/EX
// SQUASH| 10: EX redirect, flush IF/ID and ID/EX, PC takes target
// FREEZE| 11: data memory busy, whole pipeline holds
module hazard_ctrl #(
  parameter int unsigned WDOG_LIMIT = 255,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rt,
  input  logic             EX_Redirect,
  input  logic             Mem_Busy,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             Pipe_Freeze,
  output logic [1:0]       State,
  output logic             Hazard_Timeout,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt,
  output logic [CNT_W-1:0] Freeze_Cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_STALL  = 2'b01,
    ST_SQUASH = 2'b10,
    ST_FREEZE = 2'b11
  } state_e;

  localparam logic [15:0] WDOG_LIM = WDOG_LIMIT[15:0];

  state_e      dec_d;
  state_e      state_q;
  logic        lu;
  logic [15:0] wdog_q;
  logic [15:0] wdog_d;
  logic        timeout_q;
  logic        timeout_d;

  assign lu = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
              ((ID_UsesRs && (IF_ID_Rs == ID_EX_Rt)) ||
               (ID_UsesRt && (IF_ID_Rt == ID_EX_Rt)));

  // Per-cycle decision; a redirect seen while busy is simply not acted on yet,
  // EX is frozen so it is still presented once memory is ready.
  always_comb begin
    dec_d = ST_RUN;
    if (Rst)              dec_d = ST_RUN;
    else if (Mem_Busy)    dec_d = ST_FREEZE;
    else if (EX_Redirect) dec_d = ST_SQUASH;
    else if (lu)          dec_d = ST_STALL;
  end

  // Pipeline-register controls decoded from the current decision.
  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    Pipe_Freeze = 1'b0;
    case (dec_d)
      ST_STALL: begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
      end
      ST_SQUASH: begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end
      ST_FREEZE: begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        Pipe_Freeze = 1'b1;
      end
      default: ;
    endcase
  end

  // Watchdog next state: busy-run length saturating at 16 bits, sticky flag.
  always_comb begin
    wdog_d = 16'd0;
    if (Mem_Busy) wdog_d = (wdog_q == 16'hFFFF) ? wdog_q : wdog_q + 16'd1;
    timeout_d = timeout_q | (Mem_Busy && (wdog_d == WDOG_LIM));
  end

  // Registered decision and watchdog.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_RUN;
      wdog_q    <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= dec_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign State          = state_q;
  assign Hazard_Timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] freeze_cnt_q;

  // Saturating per-decision counters; they stick at all-ones rather than wrap.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (dec_d == ST_STALL  && !(&stall_cnt_q))  stall_cnt_q  <= stall_cnt_q + CNT_ONE;
      if (dec_d == ST_SQUASH && !(&flush_cnt_q))  flush_cnt_q  <= flush_cnt_q + CNT_ONE;
      if (dec_d == ST_FREEZE && !(&freeze_cnt_q)) freeze_cnt_q <= freeze_cnt_q + CNT_ONE;
    end
  end

  assign Stall_Cnt  = stall_cnt_q;
  assign Flush_Cnt  = flush_cnt_q;
  assign Freeze_Cnt = freeze_cnt_q;
`else
  assign Stall_Cnt  = '0;
  assign Flush_Cnt  = '0;
  assign Freeze_Cnt = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central hazard controller for the 5-stage pipeline. It watches the operands of the instruction in ID, the load in EX, EX-stage redirects and memory busy. From these it drives the stall, bubble and squash controls that feed the IF/ID and ID/EX pipeline registers, including `ID_EX_Flush`. It registers its last decision, runs a memory-freeze watchdog, and optionally keeps hazard performance counters.

## Interface
Parameters:
- `WDOG_LIMIT`, 255: consecutive `Mem_Busy` cycles that trigger `Hazard_Timeout` (1..65535).
- `CNT_W`, 32: width of each performance counter.

Ports:
- `Clk`  in  1  clock. One clock; reset is synchronous and active-high.
- `Rst`  in  1  synchronous active-high reset.
- `IF_ID_Rs`, `IF_ID_Rt`  in  5 each  source registers of the instruction in ID.
- `ID_UsesRs`, `ID_UsesRt`  in  1 each  ID instruction actually reads Rs / Rt.
- `ID_EX_MemRead`  in  1  instruction in EX is a load.
- `ID_EX_Rt`  in  5  destination of that load.
- `EX_Redirect`  in  1  taken branch, jump or jr resolved in EX this cycle.
- `Mem_Busy`  in  1  data memory not ready; the pipeline must hold.
- `PC_Write`  out  1  PC update enable.
- `IF_ID_Write`  out  1  IF/ID load enable.
- `IF_ID_Flush`  out  1  IF/ID loads a NOP.
- `ID_EX_Flush`  out  1  ID/EX loads a bubble (control bits cleared).
- `Pipe_Freeze`  out  1  ID/EX, EX/MEM and MEM/WB hold their contents.
- `State`  out  2  registered last decision: RUN=00, STALL=01, SQUASH=10, FREEZE=11.
- `Hazard_Timeout`  out  1  sticky watchdog flag.
- `Stall_Cnt`, `Flush_Cnt`, `Freeze_Cnt`  out  `CNT_W` each  performance counters.

## Operation
- Load-use condition `LU`: `ID_EX_MemRead` && `ID_EX_Rt`!=0 && ((`ID_UsesRs` && `IF_ID_Rs`==`ID_EX_Rt`) || (`ID_UsesRt` && `IF_ID_Rt`==`ID_EX_Rt`)).
- Decision priority per cycle: `Rst` > FREEZE (`Mem_Busy`) > SQUASH (`EX_Redirect`) > STALL (`LU`) > RUN.
- RUN: `PC_Write`=1, `IF_ID_Write`=1, both flushes 0, `Pipe_Freeze`=0.
- STALL: `PC_Write`=0, `IF_ID_Write`=0, `ID_EX_Flush`=1, `IF_ID_Flush`=0, `Pipe_Freeze`=0.
- SQUASH: `PC_Write`=1, `IF_ID_Write`=1, `IF_ID_Flush`=1, `ID_EX_Flush`=1, `Pipe_Freeze`=0.
- FREEZE: `PC_Write`=0, `IF_ID_Write`=0, both flushes 0, `Pipe_Freeze`=1.
- A redirect that arrives during FREEZE is not latched. EX is frozen, so `EX_Redirect` stays asserted and the redirect is acted on in the first non-busy cycle.
- A load-use stall lasts exactly one cycle: the bubble clears `ID_EX_MemRead`, so `LU` cannot recur for the same pair.
- `State` is loaded every cycle with that cycle's decision encoding.
- Watchdog: a 16-bit run counter increments on each `Mem_Busy` cycle, saturates at 65535, and clears to 0 on any cycle with `Mem_Busy`=0.
  - `Hazard_Timeout` sets on the edge at which the run counter reaches `WDOG_LIMIT`.
  - It stays set until `Rst`.

## Timing
- Control outputs are combinational from the current inputs: zero latency, valid within the same cycle.
- `State`, `Hazard_Timeout` and the counters update on posedge `Clk`, one cycle after the decision.
- While `Rst`=1, control outputs take the RUN values regardless of other inputs.
- Reset values: `State`=00, `Hazard_Timeout`=0, watchdog run counter=0, all performance counters=0.
- Asserting `Rst` mid-freeze or mid-stall fully clears the watchdog and counters on that edge.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `Stall_Cnt` increments on STALL cycles, `Flush_Cnt` on SQUASH cycles, `Freeze_Cnt` on FREEZE cycles.
  - Each counter saturates at all-ones and never wraps.
- `HAZARD_PERF_CNT_EN` undefined: no counter registers are built and all three outputs are tied to 0.

## Test plan
- Reset: `Rst`=1 with `Mem_Busy`=1 and `EX_Redirect`=1 -> `PC_Write`=1, `IF_ID_Write`=1, flushes 0, `Pipe_Freeze`=0; after the edge `State`=00 and all counters are 0.
- Load-use: `ID_EX_MemRead`=1, `ID_EX_Rt`=8, `IF_ID_Rs`=8, `ID_UsesRs`=1 -> `PC_Write`=0, `IF_ID_Write`=0, `ID_EX_Flush`=1 for one cycle, then `State`=01 and `Stall_Cnt`=1. Repeat with `ID_EX_Rt`=0 and `IF_ID_Rs`=0 -> RUN.
- Redirect with load-use in the same cycle -> SQUASH outputs (`IF_ID_Flush`=1, `ID_EX_Flush`=1, `PC_Write`=1); `Flush_Cnt` +1, `Stall_Cnt` unchanged, `State`=10.
- `Mem_Busy`=1 for 3 cycles with `EX_Redirect`=1 held -> 3 FREEZE cycles with `Pipe_Freeze`=1 and no flush, `Freeze_Cnt`=3; the first cycle after `Mem_Busy` drops is SQUASH.
- Watchdog with `WDOG_LIMIT`=4:
  - 3 busy cycles, 1 idle, 3 busy -> `Hazard_Timeout`=0.
  - 4 consecutive busy cycles -> `Hazard_Timeout`=1 after the 4th edge, and it stays 1 after `Mem_Busy` drops until `Rst`.
- Saturation with `CNT_W`=4: 20 separate load-use stalls -> `Stall_Cnt`=15 and holds at 15.
